// File: rtl/t1b_cs_emulator.sv
// Colour-sensor frequency emulator: per-filter programmable square wave.
// Optional phase jitter from an 8-bit LFSR when CS_EMU_JITTER_EN is defined.
module t1b_cs_emulator #(
    parameter int HALF_W        = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk_1MHz,
    input  logic              rst_n,
    input  logic [1:0]        filter,
    input  logic [1:0]        scale,
    input  logic [HALF_W-1:0] red_half,
    input  logic [HALF_W-1:0] green_half,
    input  logic [HALF_W-1:0] blue_half,
    input  logic [HALF_W-1:0] clear_half,
    output logic              cs_out,
    output logic [15:0]       pulse_count,
    output logic              settling
);

    typedef enum logic [1:0] {S_OFF, S_SETTLE, S_HIGH, S_LOW} state_t;

    localparam int CW = 13;
    localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    filter_q, filter_d;
    logic          init_q, init_d;
    logic          cs_q, cs_d;
    logic          st_q, st_d;
    logic [15:0]   pc_q, pc_d;

    logic [HALF_W-1:0] sel_half;
    logic [11:0]       h;
    logic [CW-1:0]     phase_len;
    logic              off, chg, adv;

`ifdef CS_EMU_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d, lfsr_nxt;
`endif

    always_comb begin
        case (filter)
            2'b00:   sel_half = red_half;
            2'b01:   sel_half = blue_half;
            2'b10:   sel_half = clear_half;
            default: sel_half = green_half;
        endcase
        case (scale)
            2'b01:   h = 12'(sel_half) << 2;
            2'b10:   h = 12'(sel_half) << 1;
            default: h = 12'(sel_half);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        st_d     = st_q;
        pc_d     = pc_q;
        filter_d = filter;
        init_d   = 1'b0;
        adv      = 1'b0;
        off      = (scale == 2'b00) || (sel_half == '0);
        // The first edge after reset only captures filter, it is not a change.
        chg      = !init_q && (filter != filter_q);
`ifdef CS_EMU_JITTER_EN
        lfsr_d    = lfsr_q;
        lfsr_nxt  = {lfsr_q[6:0],
                     lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        phase_len = {1'b0, h} + {12'd0, lfsr_nxt[0]};
`else
        phase_len = {1'b0, h};
`endif
        if (chg) pc_d = '0;
        if (off) begin
            state_d = S_OFF;
            cs_d    = 1'b0;
            st_d    = 1'b0;
        end else if (state_q == S_OFF || chg) begin
            state_d = S_SETTLE;
            cnt_d   = SET_LD;
            cs_d    = 1'b0;
            st_d    = 1'b1;
        end else if (cnt_q > 1) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            adv   = 1'b1;
            cnt_d = phase_len;
            st_d  = 1'b0;
            if (state_q == S_HIGH) begin
                state_d = S_LOW;
                cs_d    = 1'b0;
            end else begin
                state_d = S_HIGH;
                cs_d    = 1'b1;
                if (pc_q != 16'hFFFF) pc_d = pc_q + 1'b1;
            end
        end
`ifdef CS_EMU_JITTER_EN
        if (adv) lfsr_d = lfsr_nxt;
`endif
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SETTLE;
            cnt_q    <= SET_LD;
            filter_q <= 2'b11;
            init_q   <= 1'b1;
            cs_q     <= 1'b0;
            st_q     <= 1'b1;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            filter_q <= filter_d;
            init_q   <= init_d;
            cs_q     <= cs_d;
            st_q     <= st_d;
            pc_q     <= pc_d;
        end
    end

`ifdef CS_EMU_JITTER_EN
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign cs_out      = cs_q;
    assign pulse_count = pc_q;
    assign settling    = st_q;

endmodule
